// File: rtl/uart_batch_receiver_pkg.sv
// uart_batch_receiver_pkg
//   Shared definitions for the UART batch receiver: the byte-decoder state
//   encoding and the oversampling tick constants used by uart_rx_deser.
package uart_batch_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // The start bit is re-checked on the 8th tick after detection (tick index 7),
  // which lands near the middle of the start bit at 16x oversampling.
  localparam int START_SAMPLE_TICKS = 7;
  localparam int BIT_TICKS          = 16;

endpackage

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Decodes one UART frame (start, DBITS data LSB first, one stop bit) from
//   the synchronized serial line, advancing only on 16x sample ticks.
//   Ports:
//     clk_100MHz  in   clock
//     reset_n     in   async active-low reset
//     rx_sync     in   synchronized serial line
//     tick        in   one-clock 16x sample tick
//     byte_data   out  last decoded byte
//     byte_done   out  one-clock pulse: byte received with a valid stop bit
//     byte_err    out  one-clock pulse: stop bit sampled low, byte discarded
//     rx_idle     out  decoder is waiting for a start bit
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | line idle, waiting for rx low on a tick
//   ST_START | counting to mid start bit, re-checking rx low
//   ST_DATA  | sampling one data bit every BIT_TICKS ticks
//   ST_STOP  | waiting SB_TICK ticks, then sampling the stop bit
module uart_rx_deser
  import uart_batch_receiver_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             rx_sync,
  input  logic             tick,
  output logic [DBITS-1:0] byte_data,
  output logic             byte_done,
  output logic             byte_err,
  output logic             rx_idle
);

  // Tick counter is wide enough for SB_TICK up to 32.
  localparam int TW = 5;
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  rx_state_t        state_q, state_d;
  logic [TW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] b_q, b_d;
  logic             done_d, err_d;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      byte_done <= done_d;
      byte_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_d = ST_START;
            s_d     = '0;
          end
        end
        ST_START: begin
          if (s_q == TW'(START_SAMPLE_TICKS)) begin
            if (!rx_sync) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high: treat as a glitch, silently.
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (s_q == TW'(BIT_TICKS - 1)) begin
            s_d = '0;
            b_d = {rx_sync, b_q[DBITS-1:1]};
            if (n_q == NW'(DBITS - 1)) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (s_q == TW'(SB_TICK - 1)) begin
            state_d = ST_IDLE;
            if (rx_sync) done_d = 1'b1;
            else         err_d  = 1'b1;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign byte_data = b_q;
  assign rx_idle   = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_batch_receiver.sv
// uart_batch_receiver
//   Receives UART bytes and packs BATCH_BYTES of them into one word, first
//   byte in the most significant lane, presented with a valid/ready handshake.
//   Optional feature macro: UART_BATCH_TIMEOUT_EN (drops a partial batch after
//   TIMEOUT_TICKS idle sample ticks and pulses timeout_err).
//   Ports:
//     clk_100MHz   in   clock
//     reset_n      in   async active-low reset
//     rx           in   asynchronous serial line, idle high
//     batch_out    out  completed batch
//     batch_valid  out  batch_out holds an unconsumed batch
//     batch_ready  in   consumer accepts batch_out this cycle
//     byte_count   out  bytes in the current partial batch
//     frame_err    out  pulse: stop bit low, partial batch dropped
//     overrun_err  out  pulse: batch completed while previous one unconsumed
//     timeout_err  out  pulse: partial batch dropped after idle timeout
module uart_batch_receiver
  import uart_batch_receiver_pkg::*;
#(
  parameter int DBITS         = 8,
  parameter int SB_TICK       = 16,
  parameter int BATCH_BYTES   = 4,
  parameter int BR_LIMIT      = 54,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                             clk_100MHz,
  input  logic                             reset_n,
  input  logic                             rx,
  output logic [DBITS*BATCH_BYTES-1:0]     batch_out,
  output logic                             batch_valid,
  input  logic                             batch_ready,
  output logic [$clog2(BATCH_BYTES+1)-1:0] byte_count,
  output logic                             frame_err,
  output logic                             overrun_err,
  output logic                             timeout_err
);

  localparam int BW  = DBITS * BATCH_BYTES;
  localparam int CW  = $clog2(BATCH_BYTES + 1);
  localparam int BRW = (BR_LIMIT > 1) ? $clog2(BR_LIMIT) : 1;

  logic             rx_meta, rx_sync;
  logic [BRW-1:0]   br_cnt;
  logic             tick;
  logic [DBITS-1:0] byte_data;
  logic             byte_done, byte_err, rx_idle;
  logic [BW-1:0]    batch_shift;
  logic             timeout_hit;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (br_cnt == BRW'(BR_LIMIT - 1));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)  br_cnt <= '0;
    else if (tick) br_cnt <= '0;
    else           br_cnt <= br_cnt + BRW'(1);
  end

  uart_rx_deser #(
    .DBITS   (DBITS),
    .SB_TICK (SB_TICK)
  ) u_deser (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .rx_sync    (rx_sync),
    .tick       (tick),
    .byte_data  (byte_data),
    .byte_done  (byte_done),
    .byte_err   (byte_err),
    .rx_idle    (rx_idle)
  );

`ifdef UART_BATCH_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  logic [TOW-1:0] idle_cnt;

  assign timeout_hit = tick && rx_idle && (byte_count != '0) &&
                       (idle_cnt == TOW'(TIMEOUT_TICKS - 1));

  // Any activity on the line (decoder leaving idle) restarts the idle count.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)                          idle_cnt <= '0;
    else if (!rx_idle || byte_count == '0) idle_cnt <= '0;
    else if (tick)                         idle_cnt <= timeout_hit ? '0 : idle_cnt + TOW'(1);
  end
`else
  // TIMEOUT_TICKS is always positive, so this is a constant 0; the terms only
  // keep the otherwise unused parameter and decoder status referenced.
  assign timeout_hit = rx_idle & (TIMEOUT_TICKS < 0);
`endif

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      batch_shift <= '0;
      batch_out   <= '0;
      batch_valid <= 1'b0;
      byte_count  <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      if (batch_valid && batch_ready) batch_valid <= 1'b0;
      if (byte_err) begin
        byte_count <= '0;
        frame_err  <= 1'b1;
      end else if (byte_done) begin
        batch_shift <= {batch_shift[BW-DBITS-1:0], byte_data};
        if (byte_count == CW'(BATCH_BYTES - 1)) begin
          byte_count <= '0;
          // A handshake completing this cycle frees the slot for the new batch.
          if (!batch_valid || batch_ready) begin
            batch_out   <= {batch_shift[BW-DBITS-1:0], byte_data};
            batch_valid <= 1'b1;
          end else begin
            overrun_err <= 1'b1;
          end
        end else begin
          byte_count <= byte_count + CW'(1);
        end
      end else if (timeout_hit) begin
        byte_count  <= '0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_batch_receiver.sv
module tb_uart_batch_receiver;

  localparam int DBITS         = 8;
  localparam int SB_TICK       = 16;
  localparam int BATCH_BYTES   = 4;
  localparam int BR_LIMIT      = 4;
  localparam int TIMEOUT_TICKS = 640;
  localparam int BIT_CLKS      = 16 * BR_LIMIT;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b1;
  logic        rx         = 1'b1;
  logic        batch_ready = 1'b0;
  logic [31:0] batch_out;
  logic        batch_valid;
  logic [2:0]  byte_count;
  logic        frame_err, overrun_err, timeout_err;

  uart_batch_receiver #(
    .DBITS         (DBITS),
    .SB_TICK       (SB_TICK),
    .BATCH_BYTES   (BATCH_BYTES),
    .BR_LIMIT      (BR_LIMIT),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx          (rx),
    .batch_out   (batch_out),
    .batch_valid (batch_valid),
    .batch_ready (batch_ready),
    .byte_count  (byte_count),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int tests = 0;
  int fails = 0;
  int n_frame = 0, n_overrun = 0, n_timeout = 0, n_valid = 0;
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_out   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: runs on the falling edge, away from DUT updates.
  always @(negedge clk_100MHz) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err)   n_frame++;
      if (overrun_err) n_overrun++;
      if (timeout_err) n_timeout++;
      if (batch_valid) n_valid++;
      if (prev_valid && batch_valid && batch_out !== prev_out) begin
        tests++;
        fails++;
        $display("FAIL hold: batch_out changed 0x%0h -> 0x%0h while valid", prev_out, batch_out);
      end
      if (batch_valid && batch_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_batch: got 0x%0h expected none", batch_out);
        end else begin
          check("batch_out", batch_out, exp_q.pop_front());
        end
        prev_valid = 1'b0;
      end else begin
        prev_valid = batch_valid;
      end
      prev_out = batch_out;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  // A bad stop bit is held low only ~3/4 bit so the line is high again before
  // the decoder's glitch check on the trailing low level.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT_CLKS);
    end
    rx = stop_ok;
    cyc(stop_ok ? BIT_CLKS : (BIT_CLKS * 3) / 4);
    rx = 1'b1;
    cyc(stop_ok ? 16 : 2 * BIT_CLKS);
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) cyc(1);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200_0000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, t0, v0;
    // Reset values
    cyc(2);
    reset_n = 1'b0;
    #1;
    check("rst_valid", batch_valid, 0);
    check("rst_out", batch_out, 0);
    check("rst_count", byte_count, 0);
    check("rst_errs", {frame_err, overrun_err, timeout_err}, 0);
    cyc(5);
    reset_n = 1'b1;
    cyc(20);

    // Single good batch with ready held high
    batch_ready = 1'b1;
    f0 = n_frame; o0 = n_overrun; v0 = n_valid;
    exp_q.push_back(32'h12345678);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    drain("batch1_seen", 200);
    cyc(5);
    check("batch1_valid_cycles", n_valid - v0, 1);
    check("batch1_errs", (n_frame - f0) + (n_overrun - o0), 0);
    check("batch1_count", byte_count, 0);

    // Start-bit glitch of 3 ticks
    f0 = n_frame;
    rx = 1'b0;
    cyc(3 * BR_LIMIT);
    rx = 1'b1;
    cyc(3 * BIT_CLKS);
    check("glitch_count", byte_count, 0);
    check("glitch_frame", n_frame - f0, 0);

    // Framing error discards partial batch
    send_byte(8'h12, 1'b1);
    check("pre_ferr_count", byte_count, 1);
    send_byte(8'h34, 1'b0);
    check("ferr_pulse", n_frame - f0, 1);
    check("ferr_count", byte_count, 0);
    exp_q.push_back(32'hA1B2C3D4);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    drain("ferr_batch_seen", 200);

    // Overrun: consumer stalled across two batches
    batch_ready = 1'b0;
    o0 = n_overrun;
    exp_q.push_back(32'h01020304);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("ovr_valid", batch_valid, 1);
    check("ovr_out", batch_out, 32'h01020304);
    check("ovr_pulse", n_overrun - o0, 1);
    batch_ready = 1'b1;
    cyc(1);
    check("ovr_valid_clear", batch_valid, 0);
    check("ovr_drained", exp_q.size(), 0);

    // Idle timeout on a partial batch
    t0 = n_timeout;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("to_pre_count", byte_count, 2);
    cyc(TIMEOUT_TICKS * BR_LIMIT + 100);
`ifdef UART_BATCH_TIMEOUT_EN
    check("to_pulse", n_timeout - t0, 1);
    check("to_count", byte_count, 0);
`else
    check("to_pulse", n_timeout - t0, 0);
    check("to_count", byte_count, 2);
`endif

    // Reset in the middle of a byte
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    cyc(3 * BIT_CLKS + 10);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", batch_out, 0);
    check("mid_rst_valid", batch_valid, 0);
    check("mid_rst_count", byte_count, 0);
    check("mid_rst_errs", {frame_err, overrun_err, timeout_err}, 0);
    rx = 1'b1;
    cyc(5);
    reset_n = 1'b1;
    cyc(2 * BIT_CLKS);
    exp_q.push_back(32'hDEADBEEF);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    drain("post_rst_batch_seen", 200);

    cyc(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_batch_receiver.md
UART_BATCH_RECEIVER -- requirements
Module: uart_batch_receiver

Interface
REQ-001 SHALL have parameter DBITS, default 8, data bits per byte.
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks per stop bit.
REQ-003 SHALL have parameter BATCH_BYTES, default 4, bytes per batch.
REQ-004 SHALL have parameter BR_LIMIT, default 54, clocks per 16x sample tick (115200 baud at 100 MHz).
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 640, sample ticks of idle line before a partial batch is dropped.
REQ-006 SHALL have port clk_100MHz  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port batch_out  output  DBITS*BATCH_BYTES  completed batch; first received byte in the most significant lane.
REQ-010 SHALL have port batch_valid  output  1  batch_out holds an unconsumed batch.
REQ-011 SHALL have port batch_ready  input  1  consumer accepts batch_out this cycle.
REQ-012 SHALL have port byte_count  output  clog2(BATCH_BYTES+1)  bytes of the current partial batch.
REQ-013 SHALL have ports frame_err, overrun_err, timeout_err  output  1 each  single-cycle error pulses.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL generate a one-clock sample tick every BR_LIMIT clocks from a free-running counter that wraps at BR_LIMIT-1.
REQ-016 SHALL decode each byte with FSM IDLE, START, DATA, STOP, advancing only on sample ticks.
REQ-017 IDLE->START on synchronized rx low; START: after 7 ticks, rx low -> DATA, rx high -> IDLE (glitch rejected, no error).
REQ-018 DATA: sample every 16 ticks, LSB first, DBITS samples, then ->STOP.
REQ-019 STOP: after SB_TICK ticks sample rx; high -> byte accepted; low -> frame_err pulse, byte discarded, byte_count cleared to 0; ->IDLE either way.
REQ-020 Accepted byte SHALL shift into the batch register and increment byte_count; on the BATCH_BYTES-th byte, batch_out loads, batch_valid sets next cycle, and byte_count returns to 0.
REQ-021 batch_valid SHALL clear the cycle after batch_valid&batch_ready; batch_out SHALL stay stable while batch_valid is high.
REQ-022 A batch completing while batch_valid is high and batch_ready is low SHALL be dropped with an overrun_err pulse; batch_out is unchanged.
REQ-023 A batch completing in the same cycle as an accepting handshake SHALL load; batch_valid stays high.
REQ-024 frame_err and batch completion SHALL be mutually exclusive; a byte never both completes a batch and errors.

Reset
REQ-025 reset_n low SHALL asynchronously force FSM=IDLE, synchronizer flops=1, all counters=0, batch_out=0, batch_valid=0, byte_count=0, all error pulses=0.
REQ-026 Reset mid-byte or mid-batch SHALL discard the partial data; reception resumes at the next start bit after release.

Configuration
REQ-027 With macro UART_BATCH_TIMEOUT_EN defined, an idle counter SHALL count ticks in IDLE while byte_count!=0, reset on each start bit, and at TIMEOUT_TICKS clear byte_count with a timeout_err pulse.
REQ-028 Without UART_BATCH_TIMEOUT_EN, partial batches SHALL persist indefinitely and timeout_err SHALL be tied 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the 7-tick start-sample constant, and the 16-tick bit-period constant.
REQ-030 Byte decoding (REQ-016..019) SHALL be sub-module uart_rx_deser with outputs byte_data, byte_done, byte_err; batch assembly and handshake stay in the top.

Verification (BR_LIMIT=4, DBITS=8, BATCH_BYTES=4, TIMEOUT_TICKS=640)
REQ-031 Send 0x12,0x34,0x56,0x78 with batch_ready=1 -> one batch_valid cycle, batch_out=0x12345678, no errors.
REQ-032 rx low pulse of 3 ticks -> FSM returns IDLE, byte_count=0, no frame_err.
REQ-033 Send 0x12, then byte 0x34 with stop bit low -> frame_err pulse, byte_count=0; next 4 good bytes form a correct batch.
REQ-034 batch_ready=0, send 8 bytes 0x01..0x08 -> batch_out=0x01020304 held, one overrun_err pulse; raise batch_ready -> batch_valid clears next cycle.
REQ-035 Macro defined: send 0xAA, 0xBB, idle 640 ticks -> timeout_err pulse, byte_count=0; macro undefined: byte_count stays 2.
REQ-036 Assert reset_n low during second byte -> outputs at reset values immediately; after release, 4 bytes 0xDE,0xAD,0xBE,0xEF -> batch_out=0xDEADBEEF.
